// File: rtl/sseg_arbiter.sv
// Round-robin arbiter sharing one seven-segment driver between N_REQ requesters.
// Each granted word is held on the display for at least DWELL_EFF cycles before the next grant.
module sseg_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DWELL     = 200_000_000,
  parameter     DBG       = "FALSE",
  parameter int DWELL_DBG = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [32*N_REQ-1:0]        req_data,
  output logic [N_REQ-1:0]           req_ack,
  output logic [31:0]                disp_din,
  output logic                       disp_load,
  input  logic                       disp_busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       active
);

  localparam int DWELL_EFF = (DBG == "TRUE") ? DWELL_DBG : DWELL;
  localparam int CW        = $clog2(DWELL_EFF) + 1;
  localparam int GW        = $clog2(N_REQ);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_EFF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DWELL_ST = 2'd2
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   dwell_cnt_reg;
  logic [GW-1:0]   last_grant_reg;
  logic [GW-1:0]   winner;
  logic [GW-1:0]   scan_idx;
  logic            any_valid;
  logic [31:0]     words [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
    assign words[gi] = req_data[32*gi +: 32];
  end

  // Scan downward in distance so the closest requester after last_grant is the last one written.
  always_comb begin
    winner    = '0;
    scan_idx  = '0;
    any_valid = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      scan_idx = GW'((int'(last_grant_reg) + k) % N_REQ);
      if (req_valid[scan_idx]) begin
        winner    = scan_idx;
        any_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      disp_din       <= '0;
      disp_load      <= 1'b0;
      req_ack        <= '0;
      grant_id       <= '0;
      active         <= 1'b0;
      dwell_cnt_reg  <= '0;
      last_grant_reg <= GW'(N_REQ - 1);
    end else begin
      req_ack   <= '0;
      disp_load <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_valid) begin
            disp_din  <= words[winner];
            grant_id  <= winner;
            req_ack   <= N_REQ'(1) << winner;
            active    <= 1'b1;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          if (!disp_busy) begin
            disp_load     <= 1'b1;
            dwell_cnt_reg <= '0;
            state_reg     <= DWELL_ST;
          end
        end
        DWELL_ST: begin
          // Counter saturates; a busy driver at expiry just stretches the dwell.
          if (dwell_cnt_reg != DWELL_LAST) begin
            dwell_cnt_reg <= dwell_cnt_reg + 1'b1;
          end else if (!disp_busy) begin
            last_grant_reg <= grant_id;
            active         <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: begin
          active    <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_arbiter.sv
// Scoreboard bench for sseg_arbiter: expected grants are queued as requests are raised
// and popped when the arbiter acknowledges.
module tb_sseg_arbiter;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [32*N-1:0]  req_data;
  logic [N-1:0]     req_ack;
  logic [31:0]      disp_din;
  logic             disp_load;
  logic             disp_busy;
  logic [1:0]       grant_id;
  logic             active;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  logic [31:0] words [N];

  always #5 clk = ~clk;

  sseg_arbiter #(
    .N_REQ(4), .DWELL(200_000_000), .DBG("TRUE"), .DWELL_DBG(16)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .disp_din(disp_din), .disp_load(disp_load),
    .disp_busy(disp_busy), .grant_id(grant_id), .active(active)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int id);
    exp_t e;
    e.id   = 2'(id);
    e.data = words[id];
    sb.push_back(e);
  endtask

  task automatic wait_ack(input int budget, output int cyc);
    cyc = 0;
    while (1) begin
      tick();
      cyc++;
      if (req_ack != '0) return;
      if (cyc >= budget) begin
        cyc = -1;
        return;
      end
    end
  endtask

  task automatic wait_idle;
    int n = 0;
    while (active !== 1'b0 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (active !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: active=%b required 0 within 60 cycles", active);
    end
  endtask

  // Pops the oldest expected grant and compares it with what the DUT is presenting now.
  task automatic pop_compare(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: ack=%b with empty scoreboard", tag, req_ack);
      return;
    end
    e = sb.pop_front();
    $display("ack %s: req_ack=%b grant_id=%0d disp_din=%h", tag, req_ack, grant_id, disp_din);
    if (req_ack !== (4'b0001 << e.id) || grant_id !== e.id || disp_din !== e.data) begin
      errors++;
      $display("FAIL %s: ack=%b id=%0d din=%h required ack=%b id=%0d din=%h",
               tag, req_ack, grant_id, disp_din, 4'b0001 << e.id, e.id, e.data);
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    req_valid = 4'($urandom);
    req_data  = {$urandom, $urandom, $urandom, $urandom};
    disp_busy = 1'($urandom);
    repeat (3) tick();
    checks++;
    if ({req_ack, disp_din, disp_load, grant_id, active} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b din=%h load=%b id=%0d active=%b required all 0",
               req_ack, disp_din, disp_load, grant_id, active);
    end
    req_valid = '0;
    disp_busy = 1'b0;
    for (int i = 0; i < N; i++) req_data[32*i +: 32] = words[i];
    tick();
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if ({req_ack, disp_din, disp_load, grant_id, active} !== '0) begin
      errors++;
      $display("FAIL idle_no_valid: ack=%b din=%h load=%b id=%0d active=%b required all 0",
               req_ack, disp_din, disp_load, grant_id, active);
    end
  endtask

  task automatic test_single;
    int cyc;
    req_valid = 4'b0100;
    push_exp(2);
    wait_ack(10, cyc);
    checks++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL single_ack_latency: %0d cycles required 1", cyc);
    end
    pop_compare("single");
    req_valid = '0;
    tick();
    checks++;
    if (req_ack !== '0 || disp_load !== 1'b1) begin
      errors++;
      $display("FAIL single_load: ack=%b load=%b required ack=0000 load=1", req_ack, disp_load);
    end
    tick();
    checks++;
    if (disp_load !== 1'b0 || disp_din !== 32'h0123_4567) begin
      errors++;
      $display("FAIL single_hold: load=%b din=%h required load=0 din=01234567", disp_load, disp_din);
    end
    wait_idle();
  endtask

  task automatic test_round_robin;
    int cyc;
    int order [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    foreach (order[i]) push_exp(order[i]);
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(40, cyc);
      checks++;
      if ((n == 0 && cyc != 1) || (n > 0 && cyc != 18)) begin
        errors++;
        $display("FAIL rr_spacing: grant %0d after %0d cycles required %0d", n, cyc, (n == 0) ? 1 : 18);
      end
      pop_compare("round_robin");
    end
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_busy_load;
    int cyc;
    int early;
    req_valid = 4'b0010;
    push_exp(1);
    wait_ack(10, cyc);
    pop_compare("busy_load");
    req_valid = '0;
    disp_busy = 1'b1;
    early = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (disp_load !== 1'b0) early++;
    end
    checks++;
    if (early != 0 || active !== 1'b1) begin
      errors++;
      $display("FAIL load_withheld: %0d loads during busy, active=%b required 0 loads, active=1", early, active);
    end
    disp_busy = 1'b0;
    tick();
    checks++;
    if (disp_load !== 1'b1) begin
      errors++;
      $display("FAIL load_after_busy: load=%b required 1", disp_load);
    end
    tick();
    checks++;
    if (disp_load !== 1'b0) begin
      errors++;
      $display("FAIL load_single_pulse: load=%b required 0", disp_load);
    end
    wait_idle();
  endtask

  task automatic test_busy_dwell;
    int cyc;
    int loads;
    int acks;
    req_valid = 4'b1000;
    push_exp(3);
    wait_ack(10, cyc);
    pop_compare("busy_dwell");
    req_valid = 4'b0001;
    tick();
    checks++;
    if (disp_load !== 1'b1) begin
      errors++;
      $display("FAIL dwell_first_load: load=%b required 1", disp_load);
    end
    disp_busy = 1'b1;
    loads = 0;
    acks  = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (disp_load !== 1'b0) loads++;
      if (req_ack !== '0) acks++;
    end
    checks++;
    if (loads != 0 || acks != 0 || active !== 1'b1) begin
      errors++;
      $display("FAIL dwell_extended: loads=%0d acks=%0d active=%b required 0 0 1", loads, acks, active);
    end
    disp_busy = 1'b0;
    push_exp(0);
    wait_ack(10, cyc);
    checks++;
    if (cyc != 2) begin
      errors++;
      $display("FAIL ack_after_busy: %0d cycles after busy fell required 2", cyc);
    end
    pop_compare("after_busy");
    req_valid = '0;
    tick();
    checks++;
    if (disp_load !== 1'b1) begin
      errors++;
      $display("FAIL after_busy_load: load=%b required 1", disp_load);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid;
    int cyc;
    req_valid = 4'b0010;
    push_exp(1);
    wait_ack(10, cyc);
    pop_compare("pre_reset");
    req_valid = '0;
    repeat (5) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({req_ack, disp_din, disp_load, grant_id, active} !== '0) begin
      errors++;
      $display("FAIL async_clear: ack=%b din=%h load=%b id=%0d active=%b required all 0",
               req_ack, disp_din, disp_load, grant_id, active);
    end
    req_valid = 4'b1010;
    tick();
    tick();
    rst = 1'b0;
    push_exp(1);
    push_exp(3);
    wait_ack(5, cyc);
    pop_compare("post_reset_first");
    req_valid = 4'b1000;
    wait_ack(30, cyc);
    checks++;
    if (cyc != 18) begin
      errors++;
      $display("FAIL post_reset_spacing: %0d cycles required 18", cyc);
    end
    pop_compare("post_reset_second");
    req_valid = '0;
    wait_idle();
  endtask

  initial begin
    words[0] = 32'hA0A0_0000;
    words[1] = 32'hB1B1_1111;
    words[2] = 32'h0123_4567;
    words[3] = 32'hD3D3_3333;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    disp_busy = 1'b0;

    test_reset();
    test_single();
    test_round_robin();
    test_busy_load();
    test_busy_dwell();
    test_reset_mid();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d entries left required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
